// File: rtl/unprojection.sv
// Recovers view-space coordinates (sx*z/D, sy*z/D, z) for three vertices using one shared
// multiplier and a 64-step restoring divider. Define UNPROJ_SAT_EN to clamp results to 32-bit range.
module unprojection #(
  parameter logic signed [31:0] D = 32'sd600
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] sx1, sy1, z1,
  input  logic signed [31:0] sx2, sy2, z2,
  input  logic signed [31:0] sx3, sy3, z3,
  output logic signed [31:0] ox1, oy1, oz1,
  output logic signed [31:0] ox2, oy2, oz2,
  output logic signed [31:0] ox3, oy3, oz3,
  output logic               busy,
  output logic               finish
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, STORE} state_t;

  state_t             state_r;
  logic signed [31:0] sx_r [3];
  logic signed [31:0] sy_r [3];
  logic signed [31:0] z_r  [3];
  logic signed [31:0] ox_r [3];
  logic signed [31:0] oy_r [3];
  logic signed [31:0] oz_r [3];
  logic [2:0]         k_r;
  logic [5:0]         cnt_r;
  logic [63:0]        dvd_r;
  logic [31:0]        rem_r;
  logic               neg_r;
  logic               busy_r;
  logic               finish_r;

  logic signed [31:0] a_s, b_s;
  logic [63:0]        prod_s, mag_s;
  logic [32:0]        rem_sh_s, diff_s;
  logic               ge_s;
  logic signed [31:0] res_s;
`ifdef UNPROJ_SAT_EN
  logic [63:0]        q_s;
`else
  logic [31:0]        q_s;
`endif

  // Operand select for component k: order ox1, oy1, ox2, oy2, ox3, oy3.
  always_comb begin
    a_s = sx_r[0];
    b_s = z_r[0];
    case (k_r)
      3'd0: begin a_s = sx_r[0]; b_s = z_r[0]; end
      3'd1: begin a_s = sy_r[0]; b_s = z_r[0]; end
      3'd2: begin a_s = sx_r[1]; b_s = z_r[1]; end
      3'd3: begin a_s = sy_r[1]; b_s = z_r[1]; end
      3'd4: begin a_s = sx_r[2]; b_s = z_r[2]; end
      3'd5: begin a_s = sy_r[2]; b_s = z_r[2]; end
      default: begin a_s = sx_r[0]; b_s = z_r[0]; end
    endcase
  end

  // Sign-extended operands make the low 64 bits of the unsigned product the signed product.
  always_comb begin
    prod_s = {{32{a_s[31]}}, a_s} * {{32{b_s[31]}}, b_s};
    if (prod_s[63]) begin
      mag_s = 64'd0 - prod_s;
    end else begin
      mag_s = prod_s;
    end
  end

  // One restoring step; remainder stays below D, so a 33-bit trial subtract suffices.
  always_comb begin
    rem_sh_s = {rem_r, dvd_r[63]};
    diff_s   = rem_sh_s - {1'b0, D};
    ge_s     = ~diff_s[32];
  end

  // Signed result of the magnitude quotient, truncated toward zero.
  always_comb begin
`ifdef UNPROJ_SAT_EN
    if (neg_r) begin
      q_s = 64'd0 - dvd_r;
    end else begin
      q_s = dvd_r;
    end
    if (q_s[63:31] == {33{q_s[63]}}) begin
      res_s = q_s[31:0];
    end else if (q_s[63]) begin
      res_s = 32'sh8000_0000;
    end else begin
      res_s = 32'sh7FFF_FFFF;
    end
`else
    if (neg_r) begin
      q_s = 32'd0 - dvd_r[31:0];
    end else begin
      q_s = dvd_r[31:0];
    end
    res_s = q_s;
`endif
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      k_r      <= 3'd0;
      cnt_r    <= 6'd0;
      dvd_r    <= 64'd0;
      rem_r    <= 32'd0;
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      finish_r <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        sx_r[i] <= 32'sd0;
        sy_r[i] <= 32'sd0;
        z_r[i]  <= 32'sd0;
        ox_r[i] <= 32'sd0;
        oy_r[i] <= 32'sd0;
        oz_r[i] <= 32'sd0;
      end
    end else if (start) begin
      sx_r[0] <= sx1; sy_r[0] <= sy1; z_r[0] <= z1;
      sx_r[1] <= sx2; sy_r[1] <= sy2; z_r[1] <= z2;
      sx_r[2] <= sx3; sy_r[2] <= sy3; z_r[2] <= z3;
      oz_r[0] <= z1;
      oz_r[1] <= z2;
      oz_r[2] <= z3;
      finish_r <= 1'b0;
      busy_r   <= 1'b1;
      k_r      <= 3'd0;
      state_r  <= MUL;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        MUL: begin
          dvd_r   <= mag_s;
          rem_r   <= 32'd0;
          neg_r   <= prod_s[63];
          cnt_r   <= 6'd63;
          state_r <= DIV;
        end
        DIV: begin
          rem_r <= ge_s ? diff_s[31:0] : rem_sh_s[31:0];
          dvd_r <= {dvd_r[62:0], ge_s};
          if (cnt_r == 6'd0) begin
            state_r <= STORE;
          end else begin
            cnt_r <= cnt_r - 6'd1;
          end
        end
        STORE: begin
          case (k_r)
            3'd0: ox_r[0] <= res_s;
            3'd1: oy_r[0] <= res_s;
            3'd2: ox_r[1] <= res_s;
            3'd3: oy_r[1] <= res_s;
            3'd4: ox_r[2] <= res_s;
            3'd5: oy_r[2] <= res_s;
            default: ox_r[0] <= ox_r[0];
          endcase
          if (k_r == 3'd5) begin
            busy_r   <= 1'b0;
            finish_r <= 1'b1;
            state_r  <= IDLE;
          end else begin
            k_r     <= k_r + 3'd1;
            state_r <= MUL;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ox1    = ox_r[0];
  assign oy1    = oy_r[0];
  assign oz1    = oz_r[0];
  assign ox2    = ox_r[1];
  assign oy2    = oy_r[1];
  assign oz2    = oz_r[1];
  assign ox3    = ox_r[2];
  assign oy3    = oy_r[2];
  assign oz3    = oz_r[2];
  assign busy   = busy_r;
  assign finish = finish_r;

endmodule

// File: tb/tb_unprojection.sv
// Directed bench for unprojection: expected results are queued when a start is driven and
// compared once finish rises; latency, restart and reset-abort behaviour checked along the way.
module tb_unprojection;

  localparam logic signed [31:0] D = 32'sd600;

  logic clk = 1'b0;
  logic rst, start;
  logic signed [31:0] sx1, sy1, z1, sx2, sy2, z2, sx3, sy3, z3;
  logic signed [31:0] ox1, oy1, oz1, ox2, oy2, oz2, ox3, oy3, oz3;
  logic busy, finish;

  logic signed [31:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  string names [9] = '{"ox1", "oy1", "oz1", "ox2", "oy2", "oz2", "ox3", "oy3", "oz3"};

  always #5 clk = ~clk;

  unprojection #(.D(D)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sx1(sx1), .sy1(sy1), .z1(z1),
    .sx2(sx2), .sy2(sy2), .z2(z2),
    .sx3(sx3), .sy3(sy3), .z3(z3),
    .ox1(ox1), .oy1(oy1), .oz1(oz1),
    .ox2(ox2), .oy2(oy2), .oz2(oz2),
    .ox3(ox3), .oy3(oy3), .oz3(oz3),
    .busy(busy), .finish(finish)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: 64-bit signed product, SV "/" truncates toward zero.
  function automatic logic signed [31:0] model(input longint s, input longint z);
    longint p;
    longint q;
    p = s * z;
    q = p / longint'(D);
`ifdef UNPROJ_SAT_EN
    if (q > 64'sd2147483647) q = 64'sd2147483647;
    else if (q < -64'sd2147483648) q = -64'sd2147483648;
`endif
    return q[31:0];
  endfunction

  task automatic load(input int a1, b1, c1, a2, b2, c2, a3, b3, c3, input bit push);
    sx1 = a1; sy1 = b1; z1 = c1;
    sx2 = a2; sy2 = b2; z2 = c2;
    sx3 = a3; sy3 = b3; z3 = c3;
    if (push) begin
      exp_q.push_back(model(a1, c1)); exp_q.push_back(model(b1, c1)); exp_q.push_back(c1);
      exp_q.push_back(model(a2, c2)); exp_q.push_back(model(b2, c2)); exp_q.push_back(c2);
      exp_q.push_back(model(a3, c3)); exp_q.push_back(model(b3, c3)); exp_q.push_back(c3);
    end
  endtask

  // Holds start for n edges; returns #1 after the last start edge (edge 0).
  task automatic pulse_start(input int n);
    start = 1'b1;
    repeat (n) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    repeat (395) @(posedge clk);
    #1;
    check({tag, "_fin_e395"}, 32'(finish), 32'd0);
    check({tag, "_busy_e395"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_fin_e396"}, 32'(finish), 32'd1);
    check({tag, "_busy_e396"}, 32'(busy), 32'd0);
  endtask

  task automatic compare_all(input string tag);
    logic signed [31:0] obs [9];
    obs = '{ox1, oy1, oz1, ox2, oy2, oz2, ox3, oy3, oz3};
    for (int i = 0; i < 9; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty_", names[i]}, 32'sd1, 32'sd0);
      end else begin
        check({tag, "_", names[i]}, obs[i], exp_q.pop_front());
      end
    end
  endtask

  task automatic check_zeroed(input string tag);
    logic signed [31:0] obs [9];
    obs = '{ox1, oy1, oz1, ox2, oy2, oz2, ox3, oy3, oz3};
    for (int i = 0; i < 9; i++) check({tag, "_", names[i]}, obs[i], 32'sd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_finish"}, 32'(finish), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    load(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_zeroed("reset");
    rst = 1'b0;

    // Basic vertices, hand-checked values from the worked example.
    load(26, 30, 800, 9, 18, 650, 18, 36, 1000, 1'b1);
    pulse_start(1);
    check("t1_busy_e0", 32'(busy), 32'd1);
    check("t1_oz1_e0", oz1, 32'sd800);
    wait_finish("t1");
    check("t1_ox1_const", ox1, 32'sd34);
    check("t1_oy2_const", oy2, 32'sd19);
    compare_all("t1");

    // Negative coordinates and depth: truncation toward zero.
    load(-26, 30, 800, 9, -18, -650, 18, 36, 1000, 1'b1);
    pulse_start(1);
    wait_finish("t2");
    check("t2_ox1_const", ox1, -32'sd34);
    check("t2_ox2_const", ox2, -32'sd9);
    compare_all("t2");

    // Quotient beyond 32 bits.
    load(2000000, 5, 2000000, -7, 7, 3, 1, -1, -600, 1'b1);
    pulse_start(1);
    wait_finish("t3");
`ifdef UNPROJ_SAT_EN
    check("t3_ox1_const", ox1, 32'sd2147483647);
`else
    check("t3_ox1_const", ox1, -32'sd1923267926);
`endif
    compare_all("t3");

    // Restart at edge 100 with a new input set; the first set is abandoned.
    load(100, 200, 300, 400, 500, 600, 700, 800, 900, 1'b0);
    pulse_start(1);
    check("t4_fin_cleared", 32'(finish), 32'd0);
    repeat (99) @(posedge clk);
    #1;
    check("t4_fin_e99", 32'(finish), 32'd0);
    load(-1234, 5678, 4321, 77, -88, 99, 600, -600, 601, 1'b1);
    pulse_start(1);
    wait_finish("t4");
    compare_all("t4");

    // Reset at edge 150 aborts and clears everything.
    load(11, 22, 33, 44, 55, 66, 77, 88, 99, 1'b0);
    pulse_start(1);
    repeat (149) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_zeroed("t5_rst");
    load(-3000, 3000, 1200, 123456, -654321, 7, 1, 599, 601, 1'b1);
    pulse_start(1);
    wait_finish("t5");
    compare_all("t5");

    // Zero depth; start held for three edges, latency counts from the last one.
    load(500, 77, 0, 31, -41, 1500, -5, 6, 100000, 1'b1);
    pulse_start(3);
    wait_finish("t6");
    check("t6_ox1_const", ox1, 32'sd0);
    compare_all("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
